// File: rtl/lsb_queue.sv
// In-order load/store queue between the LSB reservation station and MemCtrl.
// Loads issue from the head immediately; stores and IO-region loads wait on the ROB.
module lsb_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TAG_W   = 4,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_store,
  input  logic [1:0]       in_size,
  input  logic             in_unsigned,
  input  logic [31:0]      in_base,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             full,
  input  logic             rob_commit,
  input  logic [TAG_W-1:0] rob_commit_tag,
  input  logic [TAG_W-1:0] rob_head_tag,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [2:0]       mem_len,
  output logic [31:0]      mem_wdata,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DISCARD} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  logic [DEPTH-1:0]   st_q, uns_q, com_q, ann_q;
  logic [1:0]         size_q  [DEPTH];
  logic [31:0]        addr_q  [DEPTH];
  logic [31:0]        wdata_q [DEPTH];
  logic [TAG_W-1:0]   tag_q   [DEPTH];

  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0]         mem_len_q, mem_len_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [31:0]        cdb_data_q, cdb_data_d;

  logic [DEPTH-1:0]   vld, com_eff;
  logic [CW-1:0]      ncom, keep;
  logic [PW-1:0]      idx;
  logic               ann_set, ann_fire, enq, pop, issue_ok;
  logic [PW-1:0]      ann_idx;

  logic               h_st, h_uns;
  logic [1:0]         h_size;
  logic [31:0]        h_addr, h_wdata;
  logic [TAG_W-1:0]   h_tag;

  assign h_st    = st_q[head_q];
  assign h_uns   = uns_q[head_q];
  assign h_size  = size_q[head_q];
  assign h_addr  = addr_q[head_q];
  assign h_wdata = wdata_q[head_q];
  assign h_tag   = tag_q[head_q];

  function automatic logic [2:0] size_len(input logic [1:0] sz);
    case (sz)
      2'b00:   size_len = 3'd1;
      2'b01:   size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_data = {24'h0, d[7:0]};
      2'b01:   store_data = {16'h0, d[15:0]};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic u, input logic [31:0] d);
    case (sz)
      2'b00:   load_ext = u ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   load_ext = u ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  // Occupancy mask, this-cycle commits, committed count and oldest unannounced store.
  always_comb begin
    vld     = '0;
    com_eff = '0;
    ncom    = '0;
    ann_set = 1'b0;
    ann_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        vld[idx] = 1'b1;
        if (!ann_set && st_q[idx] && !ann_q[idx]) begin
          ann_set = 1'b1;
          ann_idx = idx;
        end
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      com_eff[i] = com_q[i] | (rob_commit && vld[i] && (tag_q[i] == rob_commit_tag));
      if (vld[i] && com_eff[i]) ncom = ncom + CW'(1);
    end
  end

  // Memory FSM next state, registered memory/CDB outputs, pointer and count update.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_len_d   = mem_len_q;
    mem_wdata_d = mem_wdata_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    pop         = 1'b0;
    issue_ok    = h_st ? com_q[head_q] : ((h_addr < IO_BASE) || (h_tag == rob_head_tag));

    case (state_q)
      S_IDLE: begin
        // In a flush cycle only a committed store may still issue.
        if (count_q != '0 && issue_ok && (!flush || h_st)) begin
          state_d     = S_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = h_st;
          mem_addr_d  = h_addr;
          mem_len_d   = size_len(h_size);
          mem_wdata_d = h_st ? store_data(h_size, h_wdata) : '0;
        end
      end
      S_BUSY: begin
        if (mem_done) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_IDLE;
          if (!h_st && !flush) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = h_tag;
            cdb_data_d  = load_ext(h_size, h_uns, mem_rdata);
          end
        end else if (flush && !h_st) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_done) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ann_fire = ann_set && !cdb_valid_d && !flush;
    if (ann_fire) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = tag_q[ann_idx];
      cdb_data_d  = '0;
    end

    enq    = in_valid && !flush && (count_q != CW'(DEPTH));
    // A load still in flight at the head is kept so that its completion pops it.
    keep   = ncom + (((state_q != S_IDLE) && !h_st) ? CW'(1) : CW'(0));
    head_d = head_q + PW'(pop);
    if (flush) begin
      tail_d  = head_q + keep[PW-1:0];
      count_d = keep - CW'(pop);
    end else begin
      tail_d  = tail_q + PW'(enq);
      count_d = count_q + CW'(enq) - CW'(pop);
    end
  end

  // Control state, flags and output registers; frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      com_q       <= '0;
      ann_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_len_q   <= '0;
      mem_wdata_q <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_len_q   <= mem_len_d;
      mem_wdata_q <= mem_wdata_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      com_q       <= com_eff;
      if (ann_fire) ann_q[ann_idx] <= 1'b1;
      if (enq) begin
        com_q[tail_q] <= 1'b0;
        ann_q[tail_q] <= 1'b0;
      end
    end
  end

  // Entry payload written at the tail on enqueue.
  always_ff @(posedge clk) begin
    if (!rst && rdy && enq) begin
      st_q[tail_q]    <= in_store;
      uns_q[tail_q]   <= in_unsigned;
      size_q[tail_q]  <= in_size;
      addr_q[tail_q]  <= in_base + in_imm;
      wdata_q[tail_q] <= in_wdata;
      tag_q[tail_q]   <= in_tag;
    end
  end

  assign full      = (count_q >= CW'(DEPTH - 2));
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_len   = mem_len_q;
  assign mem_wdata = mem_wdata_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_lsb_queue.sv
// Testbench for lsb_queue: vector table plus scoreboarded corner-case sequences.
module tb_lsb_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, in_store, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_base, in_imm, in_wdata;
  logic [3:0]  in_tag, rob_commit_tag, rob_head_tag;
  logic        rob_commit, full;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_len;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;

  lsb_queue #(.DEPTH(16), .TAG_W(4), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_base(in_base), .in_imm(in_imm), .in_wdata(in_wdata), .in_tag(in_tag),
    .full(full), .rob_commit(rob_commit), .rob_commit_tag(rob_commit_tag),
    .rob_head_tag(rob_head_tag), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] base, imm, wdata;
    logic [3:0]  tag;
    logic [31:0] rdata, exp_addr;
    logic [2:0]  exp_len;
    logic [31:0] exp_wdata, exp_cdb;
  } vec_t;

  typedef struct { logic we; logic [31:0] addr; logic [2:0] len; logic [31:0] wdata; } mexp_t;
  typedef struct { logic [3:0] tag; logic [31:0] data; } cexp_t;

  vec_t  vecs [9];
  mexp_t mem_q [$];
  cexp_t cdb_q [$];
  mexp_t me;
  cexp_t ce;
  logic [31:0] rmem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic mem_en = 1'b1;
  logic req_prev = 1'b0;
  int unsigned wait_cnt = 0;
  localparam int unsigned LAT = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [2:0] l, input logic [31:0] d);
    mexp_t m;
    m.we = we; m.addr = a; m.len = l; m.wdata = d;
    mem_q.push_back(m);
  endtask

  task automatic exp_cdb(input logic [3:0] t, input logic [31:0] d);
    cexp_t c;
    c.tag = t; c.data = d;
    cdb_q.push_back(c);
  endtask

  task automatic enq(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] base,
                     input logic [31:0] imm, input logic [31:0] wd, input logic [3:0] tag);
    in_valid = 1'b1; in_store = st; in_size = sz; in_unsigned = uns;
    in_base = base; in_imm = imm; in_wdata = wd; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] tag);
    rob_commit = 1'b1; rob_commit_tag = tag;
    @(negedge clk);
    rob_commit = 1'b0;
  endtask

  task automatic drain(input string nm);
    int unsigned n = 0;
    while ((mem_q.size() != 0 || cdb_q.size() != 0 || mem_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mem_q.size() != 0 || cdb_q.size() != 0 || mem_req) begin
      errors++;
      $display("FAIL %s_drain: pending mem %0d cdb %0d req %0b, expected 0 0 0",
               nm, mem_q.size(), cdb_q.size(), mem_req);
    end
    mem_q.delete();
    cdb_q.delete();
  endtask

  // Memory responder: answers a held request after LAT extra cycles with a one-cycle done.
  initial begin
    mem_done = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_done) begin
        mem_done = 1'b0;
        wait_cnt = 0;
      end else if (mem_req && mem_en) begin
        if (wait_cnt == LAT) begin
          mem_done  = 1'b1;
          mem_rdata = rmem.exists(mem_addr) ? rmem[mem_addr] : 32'h0;
          if (mem_we) writes++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Output monitor: every CDB broadcast and every new memory request is scoreboarded.
  always @(negedge clk) begin
    if (!rst) begin
      if (cdb_valid) begin
        if (cdb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cdb_unexpected: got tag %h data %h, expected no broadcast", cdb_tag, cdb_data);
        end else begin
          ce = cdb_q.pop_front();
          chk("cdb_tag", 32'(cdb_tag), 32'(ce.tag));
          chk("cdb_data", cdb_data, ce.data);
        end
      end
      if (mem_req && !req_prev) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got we %b addr %h, expected no request", mem_we, mem_addr);
        end else begin
          me = mem_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(me.we));
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_len", 32'(mem_len), 32'(me.len));
          chk("mem_wdata", mem_wdata, me.wdata);
        end
      end
      req_prev = mem_req;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] iv;
    int unsigned i, n;
    int wb;

    //        st   sz     uns   base          imm           wdata         tag   rdata         addr          len   exp_wdata     exp_cdb
    vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h00000100, 32'h00000004, 32'h00000000, 4'd1, 32'hDEADBEEF, 32'h00000104, 3'd4, 32'h00000000, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'b00, 1'b0, 32'h00000200, 32'h00000000, 32'h00000000, 4'd2, 32'h00000080, 32'h00000200, 3'd1, 32'h00000000, 32'hFFFFFF80};
    vecs[2] = '{1'b0, 2'b00, 1'b1, 32'h00000200, 32'h00000000, 32'h00000000, 4'd4, 32'h00000080, 32'h00000200, 3'd1, 32'h00000000, 32'h00000080};
    vecs[3] = '{1'b0, 2'b01, 1'b0, 32'h00001000, 32'hFFFFFFFE, 32'h00000000, 4'd5, 32'h12348001, 32'h00000FFE, 3'd2, 32'h00000000, 32'hFFFF8001};
    vecs[4] = '{1'b0, 2'b01, 1'b1, 32'h00001000, 32'hFFFFFFFE, 32'h00000000, 4'd6, 32'h12348001, 32'h00000FFE, 3'd2, 32'h00000000, 32'h00008001};
    vecs[5] = '{1'b1, 2'b10, 1'b0, 32'h00000400, 32'h00000008, 32'hCAFEF00D, 4'd3, 32'h00000000, 32'h00000408, 3'd4, 32'hCAFEF00D, 32'h00000000};
    vecs[6] = '{1'b1, 2'b00, 1'b0, 32'h00000500, 32'h00000001, 32'h123456AB, 4'd7, 32'h00000000, 32'h00000501, 3'd1, 32'h000000AB, 32'h00000000};
    vecs[7] = '{1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h00000003, 32'hBEEF1234, 4'd8, 32'h00000000, 32'h00000002, 3'd2, 32'h00001234, 32'h00000000};
    vecs[8] = '{1'b0, 2'b10, 1'b0, 32'h0002FFF0, 32'h0000000C, 32'h00000000, 4'd9, 32'h55AA55AA, 32'h0002FFFC, 3'd4, 32'h00000000, 32'h55AA55AA};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_store = 1'b0; in_size = 2'b00;
    in_unsigned = 1'b0; in_base = '0; in_imm = '0; in_wdata = '0; in_tag = '0;
    rob_commit = 1'b0; rob_commit_tag = '0; rob_head_tag = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single transactions.
    for (int k = 0; k < 9; k++) begin
      if (!vecs[k].st) begin
        rmem[vecs[k].exp_addr] = vecs[k].rdata;
        exp_mem(1'b0, vecs[k].exp_addr, vecs[k].exp_len, 32'h0);
        exp_cdb(vecs[k].tag, vecs[k].exp_cdb);
      end else begin
        exp_cdb(vecs[k].tag, 32'h0);
        exp_mem(1'b1, vecs[k].exp_addr, vecs[k].exp_len, vecs[k].exp_wdata);
      end
      enq(vecs[k].st, vecs[k].sz, vecs[k].uns, vecs[k].base, vecs[k].imm, vecs[k].wdata, vecs[k].tag);
      if (vecs[k].st) begin
        repeat (4) @(negedge clk);
        chk("store_waits_commit", 32'(mem_req), 32'd0);
        commit(vecs[k].tag);
      end
      drain("vec");
    end

    // Fill to the full threshold with memory stalled, then stream 40 loads across the wrap.
    mem_en = 1'b0;
    for (i = 0; i < 14; i++) begin
      iv = i;
      rmem[32'h1000 + 4 * iv] = 32'hA0000000 + iv;
      exp_mem(1'b0, 32'h1000 + 4 * iv, 3'd4, 32'h0);
      exp_cdb(iv[3:0], 32'hA0000000 + iv);
      enq(1'b0, 2'b10, 1'b0, 32'h1000, 4 * iv, 32'h0, iv[3:0]);
      if (i == 12) chk("full_at_13", 32'(full), 32'd0);
      if (i == 13) chk("full_at_14", 32'(full), 32'd1);
    end
    mem_en = 1'b1;
    n = 0;
    while (i < 40 && n < 2000) begin
      if (!full) begin
        iv = i;
        rmem[32'h1000 + 4 * iv] = 32'hA0000000 + iv;
        exp_mem(1'b0, 32'h1000 + 4 * iv, 3'd4, 32'h0);
        exp_cdb(iv[3:0], 32'hA0000000 + iv);
        in_valid = 1'b1; in_store = 1'b0; in_size = 2'b10; in_unsigned = 1'b0;
        in_base = 32'h1000; in_imm = 4 * iv; in_wdata = '0; in_tag = iv[3:0];
        i++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("wrap_all_sent", i, 40);
    drain("wrap");

    // Flush with a load in flight: committed stores survive, the load result is suppressed.
    mem_en = 1'b0;
    rmem[32'h2000] = 32'h00000099;
    exp_mem(1'b0, 32'h2000, 3'd4, 32'h0);
    exp_cdb(4'd2, 32'h0);
    exp_cdb(4'd3, 32'h0);
    enq(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 32'h0, 4'd1);
    enq(1'b1, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h11111111, 4'd2);
    enq(1'b1, 2'b10, 1'b0, 32'h3004, 32'h0, 32'h22222222, 4'd3);
    enq(1'b0, 2'b10, 1'b0, 32'h2100, 32'h0, 32'h0, 4'd4);
    enq(1'b0, 2'b10, 1'b0, 32'h2200, 32'h0, 32'h0, 4'd5);
    repeat (3) @(negedge clk);
    commit(4'd2);
    commit(4'd3);
    exp_mem(1'b1, 32'h3000, 3'd4, 32'h11111111);
    exp_mem(1'b1, 32'h3004, 3'd4, 32'h22222222);
    wb = writes;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_load_held", 32'(mem_req), 32'd1);
    mem_en = 1'b1;
    drain("flush");
    chk("flush_write_count", writes - wb, 2);
    rmem[32'h2300] = 32'h0BADF00D;
    exp_mem(1'b0, 32'h2300, 3'd4, 32'h0);
    exp_cdb(4'd6, 32'h0BADF00D);
    enq(1'b0, 2'b10, 1'b0, 32'h2300, 32'h0, 32'h0, 4'd6);
    drain("post_flush");

    // IO-region load waits for the ROB head.
    rob_head_tag = 4'd0;
    rmem[32'h30000] = 32'h00000077;
    exp_mem(1'b0, 32'h30000, 3'd4, 32'h0);
    exp_cdb(4'd5, 32'h00000077);
    enq(1'b0, 2'b10, 1'b0, 32'h30000, 32'h0, 32'h0, 4'd5);
    repeat (6) @(negedge clk);
    chk("io_load_held", 32'(mem_req), 32'd0);
    rob_head_tag = 4'd5;
    drain("io");
    rob_head_tag = 4'hF;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
